// File: rtl/input_status_writer.sv
// Purpose: debounce the left/right/start buttons and publish a packed status word to shared RAM port A.
// Latency: raw edge to level takes 2 + DEBOUNCE_CYCLES cycles; level change to mem_req takes 2 cycles; grant to mem_we takes 1 cycle.
// Backpressure: mem_req is held in REQ until mem_grant; changes that arrive while waiting are carried into a follow-up write.
module input_status_writer #(
    parameter int unsigned       WIDTH           = 16,
    parameter logic [WIDTH-1:0]  STATUS_ADDR     = 16'd6024,
    parameter int unsigned       DEBOUNCE_CYCLES = 50000,
    parameter int unsigned       REFRESH_CYCLES  = 1000000
) (
    input  logic             core_clk_i,
    input  logic             arst_n_i,
    input  logic             left_i,
    input  logic             right_i,
    input  logic             start_i,
    input  logic             mem_grant_i,
    output logic             mem_req_o,
    output logic [WIDTH-1:0] mem_address_o,
    output logic [WIDTH-1:0] mem_data_o,
    output logic             mem_we_o
);

    // A counter value of *_LAST means this cycle completes the required run.
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] RF_LAST = 24'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        meta_q, sync_q;
    logic [2:0][15:0]  db_cnt_q, db_cnt_d;
    logic [2:0]        level_q, level_d;
    logic [2:0]        level_dly_q;
    logic [2:0]        evt_q, evt_d;
    logic [7:0]        seq_q, seq_d;
    logic              dirty_q, dirty_d;
    logic [23:0]       rf_cnt_q, rf_cnt_d;
    logic [WIDTH-1:0]  mem_data_q, mem_data_d;
    logic [WIDTH-1:0]  status_word;
    logic [2:0]        level_rise;
    logic              level_chg;
    logic              refresh_hit;
    logic              snap_en;

    // Two-flop synchroniser for the raw buttons, ordered {start, right, left}.
    always_ff @(posedge core_clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {start_i, right_i, left_i};
            sync_q <= meta_q;
        end
    end

    // Debounce: a level is accepted once it has disagreed with the current level for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i] = sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Level changes are detected against a one-cycle delayed copy, so dirty and evt update the cycle after level.
    always_comb begin
        level_chg  = (level_q != level_dly_q);
        level_rise = level_q & ~level_dly_q;
    end

    // Refresh counter: restarts after each completed write and whenever it forces a rewrite.
    always_comb begin
        refresh_hit = 1'b0;
        rf_cnt_d    = rf_cnt_q + 24'd1;
        if (state_q == S_WRITE) begin
            rf_cnt_d = '0;
        end else if (rf_cnt_q == RF_LAST) begin
            rf_cnt_d    = '0;
            refresh_hit = 1'b1;
        end
    end

    // Status word layout: {seq, 2'b00, evt, level}, zero-extended to the bus width.
    always_comb begin
        status_word       = '0;
        status_word[2:0]  = level_q;
        status_word[5:3]  = evt_q;
        status_word[15:8] = seq_q;
    end

    // Port A handshake: request, wait for the grant, then a single write cycle.
    always_comb begin
        state_d   = state_q;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        snap_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dirty_q) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_o = 1'b1;
                if (mem_grant_i) begin
                    state_d = S_WRITE;
                    snap_en = 1'b1;
                end
            end
            S_WRITE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bookkeeping: only events captured in the snapshot are cleared; new rises and changes re-arm dirty.
    always_comb begin
        evt_d      = evt_q;
        seq_d      = seq_q;
        mem_data_d = mem_data_q;
        if (snap_en) begin
            mem_data_d = status_word;
        end
        if (state_q == S_WRITE) begin
            evt_d = evt_q & ~mem_data_q[5:3];
            seq_d = seq_q + 8'd1;
        end
        evt_d   = evt_d | level_rise;
        dirty_d = (dirty_q & ~snap_en) | level_chg | refresh_hit;
    end

    // State registers; reset drops mem_req/mem_we immediately because they decode state_q.
    always_ff @(posedge core_clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= S_IDLE;
            db_cnt_q    <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            evt_q       <= '0;
            seq_q       <= '0;
            dirty_q     <= 1'b0;
            rf_cnt_q    <= '0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            evt_q       <= evt_d;
            seq_q       <= seq_d;
            dirty_q     <= dirty_d;
            rf_cnt_q    <= rf_cnt_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign mem_address_o = STATUS_ADDR;
    assign mem_data_o    = mem_data_q;

endmodule

// File: tb/tb_input_status_writer.sv
// Purpose: randomized and directed checking of input_status_writer against a behavioural model.
// Latency: outputs are compared on every falling edge against the model state.
// Backpressure: mem_grant is driven both held low (stall) and randomly.
module tb_input_status_writer;

    localparam int DB = 4;
    localparam int RF = 100;
    localparam logic [15:0] ADDR = 16'd6024;

    logic        core_clk = 1'b0;
    logic        arst_n   = 1'b0;
    logic        left     = 1'b0;
    logic        right    = 1'b0;
    logic        start    = 1'b0;
    logic        mem_grant = 1'b0;
    logic        mem_req;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_we;

    int n_checks = 0;
    int n_pass   = 0;
    logic cmp_en = 1'b0;

    input_status_writer #(
        .WIDTH           (16),
        .STATUS_ADDR     (ADDR),
        .DEBOUNCE_CYCLES (DB),
        .REFRESH_CYCLES  (RF)
    ) dut (
        .core_clk_i    (core_clk),
        .arst_n_i      (arst_n),
        .left_i        (left),
        .right_i       (right),
        .start_i       (start),
        .mem_grant_i   (mem_grant),
        .mem_req_o     (mem_req),
        .mem_address_o (mem_address),
        .mem_data_o    (mem_data),
        .mem_we_o      (mem_we)
    );

    always #5 core_clk = ~core_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // m_win holds the most recent DB synchronised samples (index 0 newest); a
    // button level flips when every sample in that window disagrees with it.
    logic [2:0]  m_s1, m_s2;
    logic [2:0]  m_win [DB];
    logic [2:0]  m_level, m_lvl_seen, m_evt;
    logic [7:0]  m_seq;
    logic        m_dirty;
    logic [15:0] m_data;
    int          m_phase;   // 0 idle, 1 requesting, 2 writing
    int          m_age;

    always @(posedge core_clk or negedge arst_n) begin : model_step
        logic [2:0] nwin [DB];
        logic [2:0] lv, rise, ev;
        logic       chg, fire, all_diff;
        logic [7:0] seq_n;
        logic [15:0] data_n;
        int         phase_n, age_n;
        if (!arst_n) begin
            m_s1 <= '0; m_s2 <= '0;
            for (int j = 0; j < DB; j++) m_win[j] <= '0;
            m_level <= '0; m_lvl_seen <= '0; m_evt <= '0; m_seq <= '0;
            m_dirty <= 1'b0; m_data <= '0; m_phase <= 0; m_age <= 0;
        end else begin
            nwin[0] = m_s2;
            for (int j = 1; j < DB; j++) nwin[j] = m_win[j-1];
            for (int i = 0; i < 3; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++) if (nwin[j][i] == m_level[i]) all_diff = 1'b0;
                lv[i] = all_diff ? ~m_level[i] : m_level[i];
            end
            chg  = (m_level != m_lvl_seen);
            rise = m_level & ~m_lvl_seen;
            fire = 1'b0;
            if (m_phase == 2) age_n = 0;
            else if (m_age + 1 == RF) begin age_n = 0; fire = 1'b1; end
            else age_n = m_age + 1;
            ev = m_evt; seq_n = m_seq; data_n = m_data; phase_n = m_phase;
            if (m_phase == 0 && m_dirty) phase_n = 1;
            if (m_phase == 1 && mem_grant) begin
                phase_n = 2;
                data_n  = {m_seq, 2'b00, m_evt, m_level};
            end
            if (m_phase == 2) begin
                phase_n = 0;
                seq_n   = m_seq + 8'd1;
                ev      = m_evt & ~m_data[5:3];
            end
            ev = ev | rise;
            m_dirty    <= (m_dirty && !(m_phase == 1 && mem_grant)) || chg || fire;
            m_s1       <= {start, right, left};
            m_s2       <= m_s1;
            m_win      <= nwin;
            m_level    <= lv;
            m_lvl_seen <= m_level;
            m_evt      <= ev;
            m_seq      <= seq_n;
            m_data     <= data_n;
            m_phase    <= phase_n;
            m_age      <= age_n;
        end
    end

    // Single compare process: every cycle, all outputs against the model.
    always @(negedge core_clk) begin
        if (cmp_en) begin
            check("req",  {31'd0, mem_req}, {31'd0, m_phase != 0});
            check("we",   {31'd0, mem_we},  {31'd0, m_phase == 2});
            check("data", {16'd0, mem_data}, {16'd0, m_data});
            check("addr", {16'd0, mem_address}, {16'd0, ADDR});
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge core_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge core_clk);
        #2 arst_n = 1'b0;
        repeat (3) @(negedge core_clk);
        #2 arst_n = 1'b1;
    endtask

    task automatic wait_we(input string tag, input int limit, output int waited);
        waited = 0;
        while (!mem_we && waited < limit) begin
            @(negedge core_clk);
            #1;
            waited++;
        end
        check({tag, "_we_seen"}, {31'd0, mem_we}, 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w, k;
        logic [15:0] d;

        // Reset state and refresh timing
        do_reset();
        cmp_en = 1'b1;
        step(1);
        check("rst_req",  {31'd0, mem_req}, 32'd0);
        check("rst_we",   {31'd0, mem_we}, 32'd0);
        check("rst_data", {16'd0, mem_data}, 32'd0);
        check("rst_addr", {16'd0, mem_address}, 32'd6024);
        k = 1;
        while (!mem_req && k < 200) begin
            step(1);
            k++;
        end
        check("refresh_req_window", {31'd0, (k >= 101 && k <= 102)}, 32'd1);
        mem_grant = 1'b1;
        wait_we("refresh", 10, w);
        check("refresh_data", {16'd0, mem_data}, 32'h0000);
        step(2);

        // Left press with grant tied high
        do_reset();
        step(1);
        left = 1'b1;
        wait_we("left", 40, w);
        check("left_data", {16'd0, mem_data}, 32'h0009);
        check("left_addr", {16'd0, mem_address}, 32'd6024);
        step(1);
        check("left_we_pulse", {31'd0, mem_we}, 32'd0);
        left = 1'b0;
        wait_we("left_rel", 40, w);
        check("left_rel_data", {16'd0, mem_data}, 32'h0100);
        step(2);

        // Glitch rejection: 3-cycle pulse on right
        do_reset();
        step(2);
        right = 1'b1;
        step(3);
        right = 1'b0;
        wait_we("glitch", 200, w);
        check("glitch_first_write_cycle", w + 5, 32'd102);
        check("glitch_data_low", {26'd0, mem_data[5:0]}, 32'd0);
        step(2);

        // Grant stall with start pressed
        mem_grant = 1'b0;
        do_reset();
        step(1);
        start = 1'b1;
        k = 0;
        while (!mem_req && k < 40) begin
            step(1);
            k++;
        end
        check("stall_req_seen", {31'd0, mem_req}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (i == 19) begin
                check("stall_req_held", {31'd0, mem_req}, 32'd1);
                check("stall_we_low", {31'd0, mem_we}, 32'd0);
            end
        end
        mem_grant = 1'b1;
        step(1);
        check("stall_we", {31'd0, mem_we}, 32'd1);
        check("stall_data", {16'd0, mem_data}, 32'h0024);
        start = 1'b0;
        step(20);

        // Right debounces during the WRITE cycle of a left write
        do_reset();
        step(1);
        left = 1'b1;
        step(3);
        right = 1'b1;
        wait_we("evw1", 40, w);
        d = mem_data;
        check("evw_first_evt", {29'd0, d[5:3]}, 32'd1);
        step(1);
        wait_we("evw2", 40, w);
        d = mem_data;
        check("evw_second_evt4", {31'd0, d[4]}, 32'd1);
        check("evw_second_data", {16'd0, d}, 32'h0113);
        left = 1'b0;
        right = 1'b0;
        step(20);

        // Randomized buttons and grant, checked each cycle by the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) left  = ~left;
            if ($urandom_range(0, 5) == 0) right = ~right;
            if ($urandom_range(0, 7) == 0) start = ~start;
            mem_grant = ($urandom_range(0, 2) != 0);
            step(1);
        end
        left = 1'b0; right = 1'b0; start = 1'b0;

        // Reset mid-transaction, then seq wrap over forced refreshes
        mem_grant = 1'b0;
        do_reset();
        step(1);
        left = 1'b1;
        k = 0;
        while (!mem_req && k < 40) begin
            step(1);
            k++;
        end
        check("midrst_req_seen", {31'd0, mem_req}, 32'd1);
        @(negedge core_clk);
        #2 arst_n = 1'b0;
        #1;
        check("midrst_req_drop", {31'd0, mem_req}, 32'd0);
        check("midrst_we_low", {31'd0, mem_we}, 32'd0);
        left = 1'b0;
        repeat (3) @(negedge core_clk);
        #2 arst_n = 1'b1;
        mem_grant = 1'b1;
        step(1);
        for (int i = 0; i < 256; i++) begin
            wait_we("wrap", 150, w);
            d = mem_data;
            if (i == 255) check("wrap_seq_255", {24'd0, d[15:8]}, 32'd255);
            step(1);
        end
        wait_we("wrap_final", 150, w);
        d = mem_data;
        check("wrap_seq_zero", {24'd0, d[15:8]}, 32'd0);
        step(2);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
